// File: rtl/rep3_pkg.sv
// Shared definitions for the triple-repetition link (transmitter and majority-decoding receiver).
// Repetition count and FSM state encoding live here so both ends agree.
package rep3_pkg;

    localparam int REP_N = 3;
    localparam logic [1:0] REP_LAST = 2'(REP_N - 1);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } rep3_state_e;

endpackage

// File: rtl/rep3_tx_if.sv
// Word-source handshake into the repetition transmitter: source drives din/din_valid,
// transmitter answers with din_ready.
interface rep3_tx_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] din;
    logic              din_valid;
    logic              din_ready;

    modport master (
        output din,
        output din_valid,
        input  din_ready
    );

    modport slave (
        input  din,
        input  din_valid,
        output din_ready
    );
endinterface

// File: rtl/rep3_rep_ctr.sv
// Mod-3 repetition counter with enable, synchronous clear and terminal-count flag (count==2).
// Shared by the transmitter and the majority-decoding receiver.
module rep3_rep_ctr
    import rep3_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       en_i,
    input  logic       clr_i,
    output logic [1:0] cnt_o,
    output logic       tc_o
);

    logic [1:0] cnt_q;
    logic [1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = 2'd0;
        end else if (en_i) begin
            cnt_d = (cnt_q == REP_LAST) ? 2'd0 : cnt_q + 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= 2'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;
    assign tc_o  = (cnt_q == REP_LAST);

endmodule

// File: rtl/rep3_tx.sv
// Triple-repetition serial transmitter: shifts a word out MSB-first, each bit held three cycles.
// Optional feature macro: REP3_TX_PARITY_EN appends an even-parity bit after the LSB.
module rep3_tx
    import rep3_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic       clk,
    input  logic       rst,
    rep3_tx_if.slave   s,
    output logic       tx_bit,
    output logic       tx_valid,
    output logic       tx_sof,
    output logic       tx_eof,
    output logic       busy
);

`ifdef REP3_TX_PARITY_EN
    localparam int NBITS = DATA_W + 1;
`else
    localparam int NBITS = DATA_W;
`endif
    localparam int CNT_W = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(NBITS - 1);

    rep3_state_e      state_q;
    logic [NBITS-1:0] shift_q;
    logic [CNT_W-1:0] bit_cnt_q;

    logic [1:0]       rep_cnt;
    logic             rep_tc;
    logic             sending;
    logic             last_copy;
    logic             ready;
    logic             load;
    logic [NBITS-1:0] load_word;

    assign sending   = (state_q == SEND);
    assign last_copy = sending && rep_tc && (bit_cnt_q == LAST_BIT);
    // Ready never looks at din_valid, so there is no combinational loop through the source.
    assign ready     = !sending || last_copy;
    assign load      = s.din_valid && ready;

`ifdef REP3_TX_PARITY_EN
    assign load_word = {s.din, ^s.din};
`else
    assign load_word = s.din;
`endif

    rep3_rep_ctr u_rep_ctr (
        .clk   (clk),
        .rst   (rst),
        .en_i  (sending),
        .clr_i (load),
        .cnt_o (rep_cnt),
        .tc_o  (rep_tc)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            bit_cnt_q <= '0;
        end else if (load) begin
            state_q   <= SEND;
            shift_q   <= load_word;
            bit_cnt_q <= '0;
        end else if (sending && rep_tc) begin
            shift_q <= {shift_q[NBITS-2:0], 1'b0};
            if (bit_cnt_q == LAST_BIT) begin
                state_q   <= IDLE;
                bit_cnt_q <= '0;
            end else begin
                bit_cnt_q <= bit_cnt_q + CNT_W'(1);
            end
        end
    end

    assign s.din_ready = ready;
    assign tx_bit      = sending && shift_q[NBITS-1];
    assign tx_valid    = sending;
    assign tx_sof      = sending && (bit_cnt_q == '0) && (rep_cnt == 2'd0);
    assign tx_eof      = last_copy;
    assign busy        = sending;

endmodule

// File: tb/tb_rep3_tx.sv
// Self-checking bench for rep3_tx: queue-based frame model, directed literal frames, random traffic.
// Honours REP3_TX_PARITY_EN the same way as the design.
module tb_rep3_tx;

    localparam int DW = 8;
`ifdef REP3_TX_PARITY_EN
    localparam int NB = DW + 1;
    localparam logic [63:0] A5_EXP = 64'b111000111000000111000111000;
    localparam logic [63:0] C3_EXP = 64'b000000111111111111000000000;
`else
    localparam int NB = DW;
    localparam logic [63:0] A5_EXP = 64'b111000111000000111000111;
    localparam logic [63:0] C3_EXP = 64'b000000111111111111000000;
`endif
    localparam int L = 3 * NB;
    localparam logic [63:0] ONES_EXP = (64'd1 << (3 * DW)) - 64'd1;

    logic clk = 1'b0;
    logic rst;
    logic tx_bit, tx_valid, tx_sof, tx_eof, busy;

    always #5 clk = ~clk;

    rep3_tx_if #(.DATA_W(DW)) bus ();

    rep3_tx #(.DATA_W(DW)) dut (
        .clk      (clk),
        .rst      (rst),
        .s        (bus),
        .tx_bit   (tx_bit),
        .tx_valid (tx_valid),
        .tx_sof   (tx_sof),
        .tx_eof   (tx_eof),
        .busy     (busy)
    );

    typedef struct packed {
        logic b;
        logic sof;
        logic eof;
    } ent_t;

    ent_t q[$];
    int   n_vec = 0;
    int   n_err = 0;
    bit   chk_en = 1'b0;

    function automatic logic [NB-1:0] frame_of(input logic [DW-1:0] w);
`ifdef REP3_TX_PARITY_EN
        return {w, ^w};
`else
        return w;
`endif
    endfunction

    // Reference: the queue holds every remaining line cycle of the current frame.
    always @(posedge clk) begin
        logic          acc;
        logic [NB-1:0] f;
        ent_t          e;
        if (rst) begin
            q.delete();
        end else begin
            acc = bus.din_valid && (q.size() <= 1);
            f   = frame_of(bus.din);
            if (q.size() > 0) void'(q.pop_front());
            if (acc) begin
                for (int k = 0; k < NB; k++) begin
                    for (int r = 0; r < 3; r++) begin
                        e.b   = f[NB-1-k];
                        e.sof = (k == 0 && r == 0);
                        e.eof = (k == NB - 1 && r == 2);
                        q.push_back(e);
                    end
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("tx_valid", tx_valid, q.size() > 0);
            chk("busy", busy, q.size() > 0);
            chk("din_ready", bus.din_ready, q.size() <= 1);
            chk("tx_bit", tx_bit, (q.size() > 0) ? q[0].b : 1'b0);
            chk("tx_sof", tx_sof, (q.size() > 0) ? q[0].sof : 1'b0);
            chk("tx_eof", tx_eof, (q.size() > 0) ? q[0].eof : 1'b0);
        end
    end

    logic [63:0] cap;
    int          sof_n, eof_n, sof_at, eof_at;

    initial begin
        rst = 1'b1;
        bus.din = '0;
        bus.din_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk_en = 1'b1;
        chk("rst_ready", bus.din_ready, 1'b1);
        chk("rst_valid", tx_valid, 1'b0);
        chk("rst_bit", tx_bit, 1'b0);
        chk("rst_busy", busy, 1'b0);
        rst = 1'b0;
        @(negedge clk);

        // Single A5 frame from idle.
        bus.din = 8'hA5;
        bus.din_valid = 1'b1;
        cap = '0; sof_at = -1; eof_at = -1;
        for (int i = 0; i < L; i++) begin
            @(negedge clk);
            cap = {cap[62:0], tx_bit};
            if (tx_sof) sof_at = i;
            if (tx_eof) eof_at = i;
            if (i == 0) begin
                bus.din_valid = 1'b0;
                bus.din = DW'($urandom);
            end
        end
        chk("A5_bits", cap, A5_EXP);
        chk("A5_sof_pos", sof_at, 0);
        chk("A5_eof_pos", eof_at, L - 1);
        @(negedge clk);
        chk("A5_idle_ready", bus.din_ready, 1'b1);
        chk("A5_idle_busy", busy, 1'b0);

        // Back-to-back A5 then 3C; valid held with junk din during the first frame.
        bus.din = 8'hA5;
        bus.din_valid = 1'b1;
        cap = '0; sof_n = 0; sof_at = 0; eof_n = 0;
        for (int i = 0; i < 2 * L; i++) begin
            @(negedge clk);
            cap = {cap[62:0], tx_bit};
            if (tx_sof) sof_n++;
            if (tx_eof) eof_n++;
            if (i == L) sof_at = int'(tx_sof);
            if (i < L - 1) begin
                bus.din_valid = 1'b1;
                bus.din = DW'($urandom);
            end else if (i == L - 1) begin
                bus.din = 8'h3C;
            end else begin
                bus.din_valid = 1'b0;
            end
        end
        chk("b2b_first", cap[2*L-1:L], A5_EXP);
        chk("b2b_second", cap[L-1:0], C3_EXP);
        chk("b2b_sof_count", sof_n, 2);
        chk("b2b_eof_count", eof_n, 2);
        chk("b2b_sof_at_L", sof_at, 1);

        // Reset mid-frame, then a clean all-ones frame.
        @(negedge clk);
        bus.din = 8'h5A;
        bus.din_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (i == 0) bus.din_valid = 1'b0;
        end
        rst = 1'b1;
        @(negedge clk);
        chk("abort_valid", tx_valid, 1'b0);
        chk("abort_busy", busy, 1'b0);
        chk("abort_ready", bus.din_ready, 1'b1);
        rst = 1'b0;
        bus.din = 8'hFF;
        bus.din_valid = 1'b1;
        cap = '0;
        for (int i = 0; i < L; i++) begin
            @(negedge clk);
            cap = {cap[62:0], tx_bit};
            if (i == 0) bus.din_valid = 1'b0;
        end
`ifdef REP3_TX_PARITY_EN
        chk("FF_bits", cap, ONES_EXP << 3);
        @(negedge clk);
        bus.din = 8'h01;
        bus.din_valid = 1'b1;
        cap = '0;
        for (int i = 0; i < L; i++) begin
            @(negedge clk);
            cap = {cap[62:0], tx_bit};
            if (i == 0) bus.din_valid = 1'b0;
        end
        chk("p01_bits", cap, 64'b111111);
`else
        chk("FF_bits", cap, ONES_EXP);
`endif

        // Random traffic with sporadic resets.
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            rst = ($urandom_range(0, 299) == 0);
            bus.din_valid = ($urandom_range(0, 3) != 0);
            bus.din = DW'($urandom);
        end
        @(negedge clk);
        rst = 1'b0;
        bus.din_valid = 1'b0;
        repeat (2 * L) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/rep3_tx.md
# rep3_tx

Serial transmitter for the triple-repetition (majority-vote) link. Accepts a parallel word over a valid/ready handshake and shifts it out MSB-first, each bit driven for three consecutive cycles, so the far end can recover every bit with a 2-of-3 majority voter. Sits between the word source and the serial link, at the opposite end from the majority-decoding receiver.

## Interface
- DATA_W, 8, payload width in bits (≥2)
- clk  input  1  rising-edge clock, the only clock
- rst  input  1  synchronous reset, active-high
- din  input  DATA_W  word to transmit, sampled on handshake
- din_valid  input  1  source has a word on din
- din_ready  output  1  block can accept a word this cycle
- tx_bit  output  1  serial line value
- tx_valid  output  1  tx_bit carries a frame copy this cycle
- tx_sof  output  1  first copy of first bit of a frame
- tx_eof  output  1  third copy of last bit of a frame
- busy  output  1  frame in progress

## Operation
- States: IDLE, SEND. Encoding 1 bit.
- IDLE: din_ready=1, tx_valid=0, tx_bit=0. On din_valid&din_ready: load shift register with din, bit_cnt=0, rep_cnt=0, go SEND.
- SEND: tx_bit = shift register MSB, tx_valid=1. rep_cnt counts 0,1,2; at rep_cnt=2 shift left by one, rep_cnt→0, bit_cnt+1.
- Frame length NBITS = DATA_W (or DATA_W+1, see Configuration); SEND lasts 3·NBITS cycles.
- tx_sof=1 when bit_cnt=0 and rep_cnt=0; tx_eof=1 when bit_cnt=NBITS-1 and rep_cnt=2.
- din_ready=1 in IDLE and on the tx_eof cycle. Handshake on the tx_eof cycle reloads and stays in SEND: next frame's first copy follows with zero gap. No handshake on tx_eof → IDLE.
- din_valid while din_ready=0 is ignored; din need not be held after the handshake.
- busy = (state==SEND).
- bit_cnt width clog2(DATA_W+1); rep_cnt 2 bits, value 3 unreachable.

## Timing
- Reset values: state IDLE, din_ready=1, tx_bit=0, tx_valid=0, tx_sof=0, tx_eof=0, busy=0; shift register and counters 0.
- rst dominates din_valid; rst mid-frame aborts the frame and outputs take reset values at the next edge. No partial frame resumes.
- Latency: handshake at edge N → tx_sof and first copy of MSB valid after edge N (cycle N+1).
- All outputs registered or decoded from registers only; no combinational path din_valid → any output except none (din_ready depends on state/counters only).
- Throughput: back-to-back, one frame per 3·NBITS cycles.

## Configuration
- REP3_TX_PARITY_EN defined: an even-parity bit (XOR of din, computed at load) is appended after the LSB, also sent three times; NBITS=DATA_W+1; tx_eof marks the parity bit's third copy.
- Undefined: no parity, NBITS=DATA_W; parity logic absent.

## Structure
- Package rep3_pkg: REP_N=3 constant, state encoding (IDLE, SEND), shared with the majority-decoding receiver.
- One sub-module: rep3_rep_ctr, mod-3 counter with enable, clear and terminal-count output (rep_cnt==2); reusable by the receiver.

## Test plan
- Reset then din=8'hA5 handshake in IDLE → 24 cycles tx_bit 111 000 111 000 000 111 000 111, tx_sof on cycle 1, tx_eof on cycle 24, then IDLE, din_ready=1.
- din=8'hA5 then 8'h3C presented on tx_eof cycle → 48 contiguous tx_valid cycles, second frame 000 000 111 111 111 111 000 000, tx_sof again on cycle 25.
- din_valid held high during frame with changing din → ignored; only word at handshake transmitted.
- rst asserted at cycle 10 of a frame → next cycle tx_valid=0, busy=0, din_ready=1; new word 8'hFF then sends 24 ones cleanly.
- REP3_TX_PARITY_EN: din=8'h01 → 27 cycles, last three tx_bit=111; din=8'hA5 → last three 000, tx_eof on cycle 27.
- DATA_W=2, din=2'b10 → 111 000, tx_sof and tx_eof on cycles 1 and 6.
